varredura_matriz_leds: RTL and testbench
========================================

Name: varredura_matriz_leds

Overview:
- Display stage downstream of the attack manager.
- Consumes the 5x7 shot map (matriz0..matriz4) and the current cursor coordinates.
- Time-multiplexes them onto the physical 5-column x 7-row LED matrix one column at a time.
- Overlays a blinking cursor at the selected cell so the player can see where the next shot lands.

Parameters:
- DIV_SCAN, 1000, clock cycles each column stays active (>=2).
- BLINK_DIV, 50, complete scan frames per cursor blink-phase toggle (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  display enable; low blanks the display and clears counters
- matriz0..matriz4  in  7 each  column N map; bit i = row i, 1 = LED lit
- coordColuna  in  3  cursor column (valid 0..4)
- coordLinha  in  3  cursor row (valid 0..6)
- mostrar_cursor  in  1  1 = overlay blinking cursor
- colunas  out  5  one-hot column select, active-high, bit N = column N
- linhas  out  7  row drive, active-low, bit i = row i (0 = LED on)
- fim_quadro  out  1  one-cycle pulse per completed frame

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Every state update happens on posedge clock.
- Internal registers:
  - presc: 0..DIV_SCAN-1
  - col_idx: 0..4
  - frame_cnt: 0..BLINK_DIV-1
  - blink: 1 bit
- Reset (reset=0 at posedge), which has priority over everything:
  - presc=0, col_idx=0, frame_cnt=0, blink=0
  - colunas=5'b00000, linhas=7'b1111111, fim_quadro=0
- enable=0 (reset=1): same register values as reset, synchronously; outputs blanked as at reset.
- Normal operation (reset=1, enable=1):
  - presc increments every cycle.
  - When presc==DIV_SCAN-1: presc->0 and col_idx advances (4 wraps to 0).
  - On the 4->0 wrap: fim_quadro=1 for that one cycle, otherwise 0.
  - On the same wrap: frame_cnt increments. If frame_cnt==BLINK_DIV-1, frame_cnt->0 and blink toggles.
- Output register (reset=1, enable=1), every cycle:
  - colunas <= one-hot(col_idx).
  - linhas <= ~dado, where dado = matriz[col_idx].
  - Cursor overlay: if mostrar_cursor=1, coordColuna<=4, coordLinha<=6 and coordColuna==col_idx, then dado[coordLinha] is replaced by blink.
- Latency:
  - Outputs lag col_idx by exactly one clock.
  - Changes to matriz*, coord* or mostrar_cursor appear on linhas one clock later, if the column is active.
- Invalid coordinates (coordColuna 5..7 or coordLinha 7): no overlay; the map is shown unmodified.
- Mid-frame input changes are taken immediately. There is no frame-level double buffering.
- Re-enable: first cycle after enable returns high gives colunas=00001. Column 0 is active for the full DIV_SCAN cycles.
- Exactly one colunas bit is high whenever reset=1 and enable=1 (after the first output cycle). No two columns are ever simultaneously active.
- Column k active duration: exactly DIV_SCAN cycles.
- Frame period: 5*DIV_SCAN cycles. Blink half-period: 5*DIV_SCAN*BLINK_DIV cycles.

Test Plan (DIV_SCAN=4, BLINK_DIV=2 throughout):
- Reset with all matriz=0, then release. Required:
  - cycle 1: colunas=00001
  - cycles 1-4: col 0; cycles 5-8: col 1; ... ; col 4 ends at cycle 20, then 00001 again
  - linhas=1111111 throughout
  - fim_quadro high for one cycle every 20 cycles
- matriz0=1110001, matriz4=1110000, mostrar_cursor=0. Required: linhas=0001110 while colunas=00001; 0001111 while 10000; 1111111 in columns 1-3.
- Cursor at coordColuna=2, coordLinha=3, mostrar_cursor=1, maps zero. Required:
  - while colunas=00100, linhas=1111111 during the first 40 cycles (blink=0)
  - linhas=1110111 during the next 40 cycles
  - toggles every 40 cycles thereafter
- Invalid cursor coordColuna=5, then coordLinha=7 with coordColuna=0, mostrar_cursor=1, matriz0=0000001. Required: never any overlay; linhas=1111110 in column 0.
- Mid-scan enable drop at col_idx=3. Required:
  - next cycle colunas=00000, linhas=1111111, fim_quadro=0
  - re-enable gives colunas=00001 for 4 cycles and blink restarts at 0
- reset=0 asserted together with enable=1 mid-frame and a matriz change. Required: outputs at reset values next cycle; scan restarts at column 0 after release.

Source files
------------

// File: rtl/varredura_matriz_leds.sv
// varredura_matriz_leds: column-multiplexed scan of a 5x7 shot map onto an LED matrix
// with a blinking cursor overlaid at the selected cell.
module varredura_matriz_leds #(
    parameter int DIV_SCAN  = 1000,
    parameter int BLINK_DIV = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] matriz0,
    input  logic [6:0] matriz1,
    input  logic [6:0] matriz2,
    input  logic [6:0] matriz3,
    input  logic [6:0] matriz4,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       mostrar_cursor,
    output logic [4:0] colunas,
    output logic [6:0] linhas,
    output logic       fim_quadro
);
    localparam int PW = $clog2(DIV_SCAN);
    localparam int FW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_SCAN - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    col_idx_q, col_idx_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    logic [4:0]    colunas_q, colunas_d;
    logic [6:0]    linhas_q, linhas_d;
    logic          fim_quadro_q, fim_quadro_d;
    logic          fim_col, fim_frame, fim_blink, cursor_on;
    logic [6:0]    dado, mask;

    always_comb begin
        fim_col      = presc_q == PRESC_MAX;
        fim_frame    = fim_col && col_idx_q == 3'd4;
        fim_blink    = fim_frame && frame_cnt_q == FRAME_MAX;
        presc_d      = fim_col ? '0 : presc_q + PW'(1);
        col_idx_d    = !fim_col ? col_idx_q : fim_frame ? 3'd0 : col_idx_q + 3'd1;
        frame_cnt_d  = !fim_frame ? frame_cnt_q : fim_blink ? '0 : frame_cnt_q + FW'(1);
        blink_d      = blink_q ^ fim_blink;
        dado         = col_idx_q == 3'd0 ? matriz0 :
                       col_idx_q == 3'd1 ? matriz1 :
                       col_idx_q == 3'd2 ? matriz2 :
                       col_idx_q == 3'd3 ? matriz3 : matriz4;
        // out-of-range coordinates never select a cell, so the raw map shows through
        cursor_on    = mostrar_cursor && coordColuna <= 3'd4 && coordLinha <= 3'd6 &&
                       coordColuna == col_idx_q;
        mask         = cursor_on ? 7'd1 << coordLinha : 7'd0;
        colunas_d    = 5'd1 << col_idx_q;
        linhas_d     = ~((dado & ~mask) | (blink_q ? mask : 7'd0));
        fim_quadro_d = fim_frame;
    end

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            presc_q      <= '0;
            col_idx_q    <= 3'd0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            colunas_q    <= 5'd0;
            linhas_q     <= 7'h7f;
            fim_quadro_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            col_idx_q    <= col_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            colunas_q    <= colunas_d;
            linhas_q     <= linhas_d;
            fim_quadro_q <= fim_quadro_d;
        end
    end

    assign colunas    = colunas_q;
    assign linhas     = linhas_q;
    assign fim_quadro = fim_quadro_q;
endmodule

// File: tb/tb_varredura_matriz_leds.sv
// tb_varredura_matriz_leds: directed and random scan checks against a cycle-count model.
module tb_varredura_matriz_leds;
    localparam int D = 4;
    localparam int B = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] m [5];
    logic [2:0] cc = 3'd0;
    logic [2:0] cl = 3'd0;
    logic       mostrar = 1'b0;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       fim_quadro;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    logic [4:0] e_col;
    logic [6:0] e_lin;
    logic       e_fim;

    varredura_matriz_leds #(.DIV_SCAN(D), .BLINK_DIV(B)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .matriz0(m[0]), .matriz1(m[1]), .matriz2(m[2]), .matriz3(m[3]), .matriz4(m[4]),
        .coordColuna(cc), .coordLinha(cl), .mostrar_cursor(mostrar),
        .colunas(colunas), .linhas(linhas), .fim_quadro(fim_quadro)
    );

    always #5 clock = ~clock;

    // n counts displayed cycles since the scan (re)started; everything follows from it
    task automatic step();
        int col;
        logic [6:0] lit;
        if (!reset || !enable) begin
            n = 0;
            e_col = 5'd0;
            e_lin = 7'h7f;
            e_fim = 1'b0;
        end else begin
            n++;
            col = ((n - 1) / D) % 5;
            lit = m[col];
            if (mostrar && cc <= 4 && cl <= 6 && int'(cc) == col)
                lit[cl] = 1'(((n - 1) / (5 * D * B)) % 2);
            e_col = 5'(1 << col);
            e_lin = ~lit;
            e_fim = (n % (5 * D)) == 0;
        end
        @(posedge clock);
        #1;
        vectors += 3;
        assert (colunas === e_col) else begin
            miscompares++;
            $error("FAIL colunas n=%0d obs=%b exp=%b", n, colunas, e_col);
        end
        assert (linhas === e_lin) else begin
            miscompares++;
            $error("FAIL linhas n=%0d obs=%b exp=%b", n, linhas, e_lin);
        end
        assert (fim_quadro === e_fim) else begin
            miscompares++;
            $error("FAIL fim_quadro n=%0d obs=%b exp=%b", n, fim_quadro, e_fim);
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m[i] = 7'd0;
        run(3);
        reset = 1'b1;
        enable = 1'b1;
        run(60);
        m[0] = 7'b1110001;
        m[4] = 7'b1110000;
        run(40);
        for (int i = 0; i < 5; i++) m[i] = 7'd0;
        cc = 3'd2;
        cl = 3'd3;
        mostrar = 1'b1;
        run(160);
        m[0] = 7'b0000001;
        cc = 3'd5;
        run(40);
        cc = 3'd0;
        cl = 3'd7;
        run(40);
        cc = 3'd2;
        cl = 3'd3;
        for (int i = 0; i < 40 && ((n / D) % 5 != 3 || n % D != 1); i++) step();
        enable = 1'b0;
        run(2);
        enable = 1'b1;
        run(100);
        for (int i = 0; i < 7; i++) step();
        reset = 1'b0;
        m[1] = 7'b1010101;
        run(2);
        reset = 1'b1;
        run(25);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) m[$urandom_range(0, 4)] = 7'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cc = 3'($urandom);
                cl = 3'($urandom);
                mostrar = 1'($urandom);
            end
            enable = $urandom_range(0, 199) != 0;
            reset = $urandom_range(0, 299) != 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
